pushbutton_event_decoder: RTL and testbench

//  Consumes the clean 1-cycle press/release pulses of the pushbutton debouncer and classifies

---
 rtl/pb_event_pkg.sv | 23 ++
 rtl/pb_tick_gen.sv | 28 ++
 rtl/pushbutton_event_decoder.sv | 126 ++++++++++++
 tb/tb_pushbutton_event_decoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pb_event_pkg.sv
// Shared types and defaults for the pushbutton gesture decoder.
// State encoding and default tick timing live here.
package pb_event_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS1,
      ST_WAIT2,
      ST_PRESS2,
      ST_LONG
   } state_t;

   localparam int DEF_CLK_DIV = 125000;
   localparam int DEF_LONG_T  = 800;
   localparam int DEF_DBL_T   = 300;
   localparam int DEF_RPT_T   = 100;
   localparam int DEF_TW      = 16;

   function automatic logic is_held(input state_t s);
      return (s == ST_PRESS1) || (s == ST_PRESS2) || (s == ST_LONG);
   endfunction

endpackage

// File: rtl/pb_tick_gen.sv
// Prescaler producing one tick every CLK_DIV clocks.
// clr_i restarts the count so the next tick is CLK_DIV cycles away.
module pb_tick_gen #(
   parameter int CLK_DIV = 125000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [PW-1:0] cnt_q;

   assign tick_o = (cnt_q == PW'(CLK_DIV - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= '0;
      end else if (tick_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/pushbutton_event_decoder.sv
// Classifies debounced press/release pulses into click, double click,
// long press and auto-repeat events.
module pushbutton_event_decoder
   import pb_event_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int LONG_T  = DEF_LONG_T,
   parameter int DBL_T   = DEF_DBL_T,
   parameter int RPT_T   = DEF_RPT_T,
   parameter int TW      = DEF_TW
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pb_down_i,
   input  logic pb_up_i,
   output logic click_o,
   output logic dbl_click_o,
   output logic long_o,
   output logic rpt_o,
   output logic hold_o,
   output logic busy_o
);

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q;
   logic          tick;
   logic          clr;
   logic          evt_down, evt_up;
   logic          hit_long, hit_dbl, hit_rpt;
   logic          click_d, dbl_d, long_d, rpt_d;

   // Simultaneous press and release cancel each other.
   assign evt_down = pb_down_i & ~pb_up_i;
   assign evt_up   = pb_up_i & ~pb_down_i;

   assign hit_long = tick && (timer_q == TW'(LONG_T - 1));
   assign hit_dbl  = tick && (timer_q == TW'(DBL_T - 1));
   assign hit_rpt  = tick && (timer_q == TW'(RPT_T - 1));

   always_comb begin
      state_d = state_q;
      click_d = 1'b0;
      dbl_d   = 1'b0;
      long_d  = 1'b0;
      rpt_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (evt_down) state_d = ST_PRESS1;
         end
         ST_PRESS1: begin
            if (evt_up) begin
               state_d = ST_WAIT2;
            end else if (hit_long) begin
               long_d  = 1'b1;
               state_d = ST_LONG;
            end
         end
         ST_WAIT2: begin
            if (evt_down) begin
               state_d = ST_PRESS2;
            end else if (hit_dbl) begin
               click_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_PRESS2: begin
            if (evt_up) begin
               dbl_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (hit_long) begin
               click_d = 1'b1;
               long_d  = 1'b1;
               state_d = ST_LONG;
            end
         end
         ST_LONG: begin
            if (evt_up) begin
               state_d = ST_IDLE;
            end else if (hit_rpt) begin
               rpt_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Every state change and every repeat restarts the time base.
   assign clr = (state_d != state_q) || rpt_d;

   pb_tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clr),
      .tick_o(tick)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i || clr) begin
         timer_q <= '0;
      end else if (tick && (timer_q != '1)) begin
         timer_q <= timer_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         click_o     <= 1'b0;
         dbl_click_o <= 1'b0;
         long_o      <= 1'b0;
         rpt_o       <= 1'b0;
      end else begin
         state_q     <= state_d;
         click_o     <= click_d;
         dbl_click_o <= dbl_d;
         long_o      <= long_d;
         rpt_o       <= rpt_d;
      end
   end

   assign hold_o = is_held(state_q);
   assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pushbutton_event_decoder.sv
// Directed gesture sequences plus random pulses against a
// cycle-count reference model of the gesture rules.
module tb_pushbutton_event_decoder;

   localparam int DIV = 4;
   localparam int LT  = 10;
   localparam int DT  = 5;
   localparam int RT  = 3;

   localparam int M_IDLE = 0, M_P1 = 1, M_W2 = 2, M_P2 = 3, M_LONG = 4;

   logic clk = 1'b0;
   logic rst_i, pb_down_i, pb_up_i;
   logic click_o, dbl_click_o, long_o, rpt_o, hold_o, busy_o;

   int vec  = 0;
   int miss = 0;
   int rel  = 0;

   int m_mode = M_IDLE;
   int m_el   = 0;
   logic [5:0] exp_v = '0;

   always #5 clk = ~clk;

   pushbutton_event_decoder #(
      .CLK_DIV(DIV),
      .LONG_T (LT),
      .DBL_T  (DT),
      .RPT_T  (RT),
      .TW     (16)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .pb_down_i  (pb_down_i),
      .pb_up_i    (pb_up_i),
      .click_o    (click_o),
      .dbl_click_o(dbl_click_o),
      .long_o     (long_o),
      .rpt_o      (rpt_o),
      .hold_o     (hold_o),
      .busy_o     (busy_o)
   );

   // Reference: each state times itself in raw clock cycles since entry.
   task automatic model_step(input logic d_raw, input logic u_raw, input logic r);
      logic d, u, c, db, l, rp, restart;
      int nm;
      if (r) begin
         m_mode = M_IDLE;
         m_el   = 0;
         exp_v  = '0;
         return;
      end
      d = d_raw & ~u_raw;
      u = u_raw & ~d_raw;
      c = 0; db = 0; l = 0; rp = 0; restart = 0;
      nm = m_mode;
      case (m_mode)
         M_IDLE: if (d) nm = M_P1;
         M_P1: begin
            if (u) nm = M_W2;
            else if (m_el == LT*DIV-1) begin l = 1; nm = M_LONG; end
         end
         M_W2: begin
            if (d) nm = M_P2;
            else if (m_el == DT*DIV-1) begin c = 1; nm = M_IDLE; end
         end
         M_P2: begin
            if (u) begin db = 1; nm = M_IDLE; end
            else if (m_el == LT*DIV-1) begin c = 1; l = 1; nm = M_LONG; end
         end
         default: begin
            if (u) nm = M_IDLE;
            else if (m_el == RT*DIV-1) begin rp = 1; restart = 1; end
         end
      endcase
      if (nm != m_mode || restart) m_el = 0;
      else m_el = m_el + 1;
      m_mode = nm;
      exp_v = {c, db, l, rp,
               (m_mode == M_P1 || m_mode == M_P2 || m_mode == M_LONG),
               (m_mode != M_IDLE)};
   endtask

   task automatic step(input logic d, input logic u);
      logic [5:0] obs;
      pb_down_i = d;
      pb_up_i   = u;
      @(posedge clk);
      model_step(d, u, rst_i);
      #1;
      rel = rel + 1;
      obs = {click_o, dbl_click_o, long_o, rpt_o, hold_o, busy_o};
      vec++;
      assert (obs === exp_v) else begin
         miss++;
         $error("FAIL model rel=%0d observed=%b expected=%b", rel, obs, exp_v);
      end
      pb_down_i = 1'b0;
      pb_up_i   = 1'b0;
   endtask

   task automatic wait_until(input int r);
      while (rel < r) step(1'b0, 1'b0);
   endtask

   task automatic chk(input string tag, input logic obs, input logic expv);
      vec++;
      assert (obs === expv) else begin
         miss++;
         $error("FAIL %s rel=%0d observed=%b expected=%b", tag, rel, obs, expv);
      end
   endtask

   initial begin
      int rate;
      rst_i = 1'b1;
      pb_down_i = 1'b0;
      pb_up_i = 1'b0;
      step(0, 0);
      step(1, 0);
      chk("reset_busy", busy_o, 1'b0);
      chk("reset_hold", hold_o, 1'b0);
      chk("reset_long", long_o, 1'b0);
      rst_i = 1'b0;
      step(0, 0);

      // Single click
      rel = 0; step(1, 0);
      wait_until(8); step(0, 1);
      wait_until(28);
      chk("sc_pre", click_o, 1'b0);
      step(0, 0);
      chk("sc_click", click_o, 1'b1);
      chk("sc_busy", busy_o, 1'b0);
      step(0, 0);
      chk("sc_width", click_o, 1'b0);
      wait_until(40);

      // Double click
      rel = 0; step(1, 0);
      wait_until(8); step(0, 1);
      wait_until(15); step(1, 0);
      wait_until(22); step(0, 1);
      chk("dc_dbl", dbl_click_o, 1'b1);
      chk("dc_busy", busy_o, 1'b0);
      wait_until(45);

      // Long press with auto-repeat
      rel = 0; step(1, 0);
      wait_until(41);
      chk("lp_long", long_o, 1'b1);
      wait_until(53);
      chk("lp_rpt1", rpt_o, 1'b1);
      wait_until(65);
      chk("lp_rpt2", rpt_o, 1'b1);
      wait_until(77);
      chk("lp_rpt3", rpt_o, 1'b1);
      wait_until(80); step(0, 1);
      chk("lp_idle", busy_o, 1'b0);
      wait_until(90);

      // Second press held becomes long
      rel = 0; step(1, 0);
      wait_until(8); step(0, 1);
      wait_until(15); step(1, 0);
      wait_until(56);
      chk("p2_click", click_o, 1'b1);
      chk("p2_long", long_o, 1'b1);
      step(0, 0);
      chk("p2_hold", hold_o, 1'b1);
      step(0, 1);
      wait_until(65);

      // Press in the very cycle the double-click window expires
      rel = 0; step(1, 0);
      wait_until(8); step(0, 1);
      wait_until(28); step(1, 0);
      chk("bd_noclick", click_o, 1'b0);
      chk("bd_hold", hold_o, 1'b1);
      wait_until(35); step(0, 1);
      chk("bd_dbl", dbl_click_o, 1'b1);
      wait_until(40);

      // Simultaneous edges ignored
      step(1, 1);
      chk("both_idle", busy_o, 1'b0);
      step(1, 0);
      step(1, 1);
      chk("both_p1", hold_o, 1'b1);
      step(0, 1);
      wait_until(rel + 25);

      // Reset mid-press
      rel = 0; step(1, 0);
      wait_until(20);
      rst_i = 1'b1; step(0, 0); rst_i = 1'b0;
      chk("rst_busy", busy_o, 1'b0);
      wait_until(41);
      chk("rst_nolong", long_o, 1'b0);
      rel = 0; step(1, 0);
      wait_until(8); step(0, 1);
      wait_until(29);
      chk("rst_click", click_o, 1'b1);

      // Random pulse trains with varying density
      for (int b = 0; b < 60; b++) begin
         rate = $urandom_range(3, 60);
         for (int i = 0; i < 60; i++) begin
            rst_i = ($urandom_range(0, 599) == 0);
            step($urandom_range(0, rate - 1) == 0,
                 $urandom_range(0, rate - 1) == 0);
         end
      end
      rst_i = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
